decode_stage_hz: RTL and testbench

Second-generation DLX instruction-decode stage: decoder, 2**REG_ADDR_WIDTH x DATA_WIDTH register bank, sign extension and ID/EX pipeline register in one block. Adds a valid bit per stage, load-use interlock (bubble + fetch stall), flush on taken branch/jump, and downstream back-pressure. Sits between fetch and execute; write-back drives its register-bank write port.

---
 rtl/dlx_decode_pkg.sv | 67 ++++++
 rtl/decode_regbank.sv | 46 ++++
 rtl/decode_stage_hz.sv | 211 +++++++++++++++++++++
 tb/tb_decode_stage_hz.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_decode_pkg.sv
// Shared constants for the DLX decode stage: opcodes, instruction field positions,
// control-word bit indices and an opcode classifier.
package dlx_decode_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CTRL_W  = 8;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS1_MSB    = 25;
  localparam int unsigned RS1_LSB    = 21;
  localparam int unsigned RS2_MSB    = 20;
  localparam int unsigned RS2_LSB    = 16;
  localparam int unsigned RD_I_MSB   = 20;
  localparam int unsigned RD_I_LSB   = 16;
  localparam int unsigned RD_R_MSB   = 15;
  localparam int unsigned RD_R_LSB   = 11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_JR    = 6'h12;
  localparam logic [5:0] OP_JALR  = 6'h13;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Control word layout, MSB first.
  localparam int unsigned CTRL_REG_WR_EN = 7;
  localparam int unsigned CTRL_MEM_RD_EN = 6;
  localparam int unsigned CTRL_MEM_WR_EN = 5;
  localparam int unsigned CTRL_WB_SEL    = 4;
  localparam int unsigned CTRL_IMM_INST  = 3;
  localparam int unsigned CTRL_BRANCH    = 2;
  localparam int unsigned CTRL_JUMP      = 1;
  localparam int unsigned CTRL_JUMP_USE_R = 0;

  typedef enum logic [3:0] {
    ClsRtype,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJump,
    ClsJumpLink,
    ClsJumpReg,
    ClsJumpRegLink,
    ClsAluImm
  } instr_class_e;

  function automatic instr_class_e classify(input logic [5:0] opcode);
    instr_class_e cls;
    case (opcode)
      OP_RTYPE:         cls = ClsRtype;
      OP_LW:            cls = ClsLoad;
      OP_SW:            cls = ClsStore;
      OP_BEQZ, OP_BNEZ: cls = ClsBranch;
      OP_J:             cls = ClsJump;
      OP_JAL:           cls = ClsJumpLink;
      OP_JR:            cls = ClsJumpReg;
      OP_JALR:          cls = ClsJumpRegLink;
      default:          cls = ClsAluImm;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/decode_regbank.sv
// Register bank with two combinational read ports; r0 is hard-wired to zero.
// Define DECODE_WB_BYPASS_EN to forward same-cycle write data to the read ports.
module decode_regbank #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0]     rd_data_a,
  output logic [DATA_WIDTH-1:0]     rd_data_b
);

  localparam int unsigned DEPTH = 2 ** REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] bank_q [DEPTH];
  logic                  wr_active;

  assign wr_active = wr_en & (wr_addr != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        bank_q[i] <= '0;
      end
    end else if (wr_active) begin
      bank_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_a = bank_q[rd_addr_a];
    rd_data_b = bank_q[rd_addr_b];
`ifdef DECODE_WB_BYPASS_EN
    if (wr_active && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
    if (wr_active && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
`endif
    if (rd_addr_a == '0) rd_data_a = '0;
    if (rd_addr_b == '0) rd_data_b = '0;
  end

endmodule

// File: rtl/decode_stage_hz.sv
// DLX decode stage with load-use interlock, flush and back-pressure feeding an ID/EX register.
// Define DECODE_WB_BYPASS_EN to make same-cycle write-back visible to decode reads.
module decode_stage_hz
  import dlx_decode_pkg::*;
#(
  parameter int unsigned PC_WIDTH        = 20,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned REG_ADDR_WIDTH  = 5,
  parameter int unsigned IMEDIATE_WIDTH  = 16,
  parameter int unsigned PC_OFFSET_WIDTH = 26,
  parameter int unsigned LINK_REG        = 31
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [INSTR_W-1:0]         instruction_in,
  input  logic [PC_WIDTH-1:0]        new_pc_in,
  input  logic                       valid_in,
  input  logic                       flush_in,
  input  logic                       ex_stall_in,
  input  logic                       wb_write_enable,
  input  logic [REG_ADDR_WIDTH-1:0]  wb_reg_wr_addr,
  input  logic [DATA_WIDTH-1:0]      wb_write_data,
  output logic                       stall_out,
  output logic                       valid_out,
  output logic [INSTR_W-1:0]         instruction_out,
  output logic [PC_WIDTH-1:0]        new_pc_out,
  output logic [REG_ADDR_WIDTH-1:0]  rs1_addr_out,
  output logic [REG_ADDR_WIDTH-1:0]  rs2_addr_out,
  output logic [REG_ADDR_WIDTH-1:0]  reg_wr_addr_out,
  output logic [CTRL_W-1:0]          ctrl_out,
  output logic [DATA_WIDTH-1:0]      constant_out,
  output logic [DATA_WIDTH-1:0]      data_alu_a_out,
  output logic [DATA_WIDTH-1:0]      data_alu_b_out,
  output logic [PC_OFFSET_WIDTH-1:0] pc_offset_out
);

  logic [5:0]                  opcode;
  instr_class_e                instr_class;
  logic [REG_ADDR_WIDTH-1:0]   rs1, rs2, rd_r, rd_i, dest;
  logic [CTRL_W-1:0]           ctrl_dec;
  logic                        uses_rs2;
  logic [DATA_WIDTH-1:0]       rs1_data, rs2_data, imm_ext;
  logic [IMEDIATE_WIDTH-1:0]   imm;
  logic                        hazard, load_entry;

  logic                        valid_d, valid_q;
  logic [INSTR_W-1:0]          instr_d, instr_q;
  logic [PC_WIDTH-1:0]         pc_d, pc_q;
  logic [REG_ADDR_WIDTH-1:0]   rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  logic [CTRL_W-1:0]           ctrl_d, ctrl_q;
  logic [DATA_WIDTH-1:0]       const_d, const_q, a_d, a_q, b_d, b_q;
  logic [PC_OFFSET_WIDTH-1:0]  off_d, off_q;

  assign opcode      = instruction_in[OPCODE_MSB:OPCODE_LSB];
  assign instr_class = classify(opcode);
  assign rs1         = REG_ADDR_WIDTH'(instruction_in[RS1_MSB:RS1_LSB]);
  assign rs2         = REG_ADDR_WIDTH'(instruction_in[RS2_MSB:RS2_LSB]);
  assign rd_r        = REG_ADDR_WIDTH'(instruction_in[RD_R_MSB:RD_R_LSB]);
  assign rd_i        = REG_ADDR_WIDTH'(instruction_in[RD_I_MSB:RD_I_LSB]);
  assign imm         = instruction_in[IMEDIATE_WIDTH-1:0];
  assign imm_ext     = {{(DATA_WIDTH - IMEDIATE_WIDTH){imm[IMEDIATE_WIDTH-1]}}, imm};

  decode_regbank #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_regbank (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wb_write_enable),
    .wr_addr   (wb_reg_wr_addr),
    .wr_data   (wb_write_data),
    .rd_addr_a (rs1),
    .rd_addr_b (rs2),
    .rd_data_a (rs1_data),
    .rd_data_b (rs2_data)
  );

  // Non-writing classes report destination 0 so EX never sees a stale write target.
  always_comb begin
    ctrl_dec = '0;
    uses_rs2 = 1'b0;
    dest     = '0;
    unique case (instr_class)
      ClsRtype: begin
        ctrl_dec[CTRL_REG_WR_EN] = 1'b1;
        uses_rs2                 = 1'b1;
        dest                     = rd_r;
      end
      ClsLoad: begin
        ctrl_dec[CTRL_REG_WR_EN] = 1'b1;
        ctrl_dec[CTRL_MEM_RD_EN] = 1'b1;
        ctrl_dec[CTRL_WB_SEL]    = 1'b1;
        dest                     = rd_i;
      end
      ClsStore: begin
        ctrl_dec[CTRL_MEM_WR_EN] = 1'b1;
        uses_rs2                 = 1'b1;
      end
      ClsBranch: ctrl_dec[CTRL_BRANCH] = 1'b1;
      ClsJump:   ctrl_dec[CTRL_JUMP]   = 1'b1;
      ClsJumpLink: begin
        ctrl_dec[CTRL_JUMP]      = 1'b1;
        ctrl_dec[CTRL_REG_WR_EN] = 1'b1;
        dest                     = REG_ADDR_WIDTH'(LINK_REG);
      end
      ClsJumpReg: begin
        ctrl_dec[CTRL_JUMP]       = 1'b1;
        ctrl_dec[CTRL_JUMP_USE_R] = 1'b1;
      end
      ClsJumpRegLink: begin
        ctrl_dec[CTRL_JUMP]       = 1'b1;
        ctrl_dec[CTRL_JUMP_USE_R] = 1'b1;
        ctrl_dec[CTRL_REG_WR_EN]  = 1'b1;
        dest                      = REG_ADDR_WIDTH'(LINK_REG);
      end
      default: begin
        ctrl_dec[CTRL_IMM_INST]  = 1'b1;
        ctrl_dec[CTRL_REG_WR_EN] = 1'b1;
        dest                     = rd_i;
      end
    endcase
    if (dest == '0) ctrl_dec[CTRL_REG_WR_EN] = 1'b0;
  end

  // Load in ID/EX whose result a decoding instruction needs: insert one bubble.
  assign hazard = valid_in & valid_q & ctrl_q[CTRL_MEM_RD_EN] & (rd_q != '0) &
                  ((rs1 == rd_q) | (uses_rs2 & (rs2 == rd_q)));

  assign stall_out  = ex_stall_in | (hazard & ~flush_in);
  assign load_entry = valid_in & ~flush_in & ~hazard;

  always_comb begin
    valid_d = 1'b0;
    instr_d = '0;
    pc_d    = '0;
    rs1_d   = '0;
    rs2_d   = '0;
    rd_d    = '0;
    ctrl_d  = '0;
    const_d = '0;
    a_d     = '0;
    b_d     = '0;
    off_d   = '0;
    if (ex_stall_in) begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      rd_d    = rd_q;
      ctrl_d  = ctrl_q;
      const_d = const_q;
      a_d     = a_q;
      b_d     = b_q;
      off_d   = off_q;
    end else if (load_entry) begin
      valid_d = 1'b1;
      instr_d = instruction_in;
      pc_d    = new_pc_in;
      rs1_d   = rs1;
      rs2_d   = rs2;
      rd_d    = dest;
      ctrl_d  = ctrl_dec;
      const_d = imm_ext;
      a_d     = rs1_data;
      b_d     = rs2_data;
      off_d   = instruction_in[PC_OFFSET_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
      const_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      off_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
      const_q <= const_d;
      a_q     <= a_d;
      b_q     <= b_d;
      off_q   <= off_d;
    end
  end

  assign valid_out       = valid_q;
  assign instruction_out = instr_q;
  assign new_pc_out      = pc_q;
  assign rs1_addr_out    = rs1_q;
  assign rs2_addr_out    = rs2_q;
  assign reg_wr_addr_out = rd_q;
  assign ctrl_out        = ctrl_q;
  assign constant_out    = const_q;
  assign data_alu_a_out  = a_q;
  assign data_alu_b_out  = b_q;
  assign pc_offset_out   = off_q;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Scoreboard bench for decode_stage_hz: expected ID/EX entries are queued at issue and
// compared when the stage presents a new valid entry.
module tb_decode_stage_hz;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction_in;
  logic [19:0] new_pc_in;
  logic        valid_in, flush_in, ex_stall_in;
  logic        wb_write_enable;
  logic [4:0]  wb_reg_wr_addr;
  logic [31:0] wb_write_data;
  logic        stall_out, valid_out;
  logic [31:0] instruction_out;
  logic [19:0] new_pc_out;
  logic [4:0]  rs1_addr_out, rs2_addr_out, reg_wr_addr_out;
  logic [7:0]  ctrl_out;
  logic [31:0] constant_out, data_alu_a_out, data_alu_b_out;
  logic [25:0] pc_offset_out;

  typedef struct packed {
    logic [31:0] instr;
    logic [19:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
    logic [31:0] cst;
    logic [31:0] a;
    logic [31:0] b;
    logic [25:0] off;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_exp, mon_got;
  logic [31:0] rf [32];
  int          checks = 0;
  int          failures = 0;
  logic        new_entry = 1'b0;

  decode_stage_hz dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instruction_in  (instruction_in),
    .new_pc_in       (new_pc_in),
    .valid_in        (valid_in),
    .flush_in        (flush_in),
    .ex_stall_in     (ex_stall_in),
    .wb_write_enable (wb_write_enable),
    .wb_reg_wr_addr  (wb_reg_wr_addr),
    .wb_write_data   (wb_write_data),
    .stall_out       (stall_out),
    .valid_out       (valid_out),
    .instruction_out (instruction_out),
    .new_pc_out      (new_pc_out),
    .rs1_addr_out    (rs1_addr_out),
    .rs2_addr_out    (rs2_addr_out),
    .reg_wr_addr_out (reg_wr_addr_out),
    .ctrl_out        (ctrl_out),
    .constant_out    (constant_out),
    .data_alu_a_out  (data_alu_a_out),
    .data_alu_b_out  (data_alu_b_out),
    .pc_offset_out   (pc_offset_out)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] r_type(input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [4:0] rd);
    return {6'h00, rs1, rs2, rd, 11'h020};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs1,
                                         input logic [4:0] rd, input logic [15:0] imm);
    return {op, rs1, rd, imm};
  endfunction

  function automatic logic [31:0] j_type(input logic [5:0] op, input logic [25:0] off);
    return {op, off};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [19:0] pc);
    instruction_in = instr;
    new_pc_in      = pc;
    valid_in       = 1'b1;
  endtask

  task automatic push_exp(input logic [31:0] instr, input logic [19:0] pc, input logic [7:0] ctrl,
                          input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.rs1   = instr[25:21];
    e.rs2   = instr[20:16];
    e.rd    = rd;
    e.ctrl  = ctrl;
    e.cst   = {{16{instr[15]}}, instr[15:0]};
    e.a     = a;
    e.b     = b;
    e.off   = instr[25:0];
    exp_q.push_back(e);
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    wb_write_enable = 1'b1;
    wb_reg_wr_addr  = addr;
    wb_write_data   = data;
    tick();
    wb_write_enable = 1'b0;
    if (addr != 5'd0) rf[addr] = data;
  endtask

  // An entry is new when the ID/EX register was allowed to update at the last edge.
  always @(posedge clk) new_entry <= rst_n & ~ex_stall_in;

  always @(negedge clk) begin
    if (new_entry) begin
      if (valid_out) begin
        checks++;
        mon_got = {instruction_out, new_pc_out, rs1_addr_out, rs2_addr_out, reg_wr_addr_out,
                   ctrl_out, constant_out, data_alu_a_out, data_alu_b_out, pc_offset_out};
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_entry: got instr=%h, expected no entry", instruction_out);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            failures++;
            $display("FAIL entry_%h: got pc=%h rs=%0d/%0d rd=%0d ctrl=%h c=%h a=%h b=%h off=%h; expected pc=%h rs=%0d/%0d rd=%0d ctrl=%h c=%h a=%h b=%h off=%h",
                     mon_exp.instr, new_pc_out, rs1_addr_out, rs2_addr_out, reg_wr_addr_out,
                     ctrl_out, constant_out, data_alu_a_out, data_alu_b_out, pc_offset_out,
                     mon_exp.pc, mon_exp.rs1, mon_exp.rs2, mon_exp.rd, mon_exp.ctrl,
                     mon_exp.cst, mon_exp.a, mon_exp.b, mon_exp.off);
          end
        end
      end else begin
        checks++;
        if (ctrl_out !== 8'h00 || instruction_out !== 32'h0) begin
          failures++;
          $display("FAIL bubble_clear: got ctrl=%h instr=%h, expected 00/00000000",
                   ctrl_out, instruction_out);
        end
      end
    end
  end

  task automatic test_reset;
    logic [31:0] ins;
    rst_n = 1'b0;
    valid_in = 1'b1; flush_in = 1'b0; ex_stall_in = 1'b0;
    wb_write_enable = 1'b0; wb_reg_wr_addr = '0; wb_write_data = '0;
    instruction_in = r_type(5'd2, 5'd3, 5'd1); new_pc_in = 20'h00abc;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    tick(); tick();
    checks++;
    if (valid_out !== 1'b0 || ctrl_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_valid_ctrl: got valid=%b ctrl=%h, expected 0/00", valid_out, ctrl_out);
    end
    checks++;
    if ({instruction_out, new_pc_out, rs1_addr_out, rs2_addr_out, reg_wr_addr_out, constant_out,
         data_alu_a_out, data_alu_b_out, pc_offset_out} !== '0) begin
      failures++;
      $display("FAIL reset_fields: got instr=%h pc=%h a=%h b=%h, expected all zero",
               instruction_out, new_pc_out, data_alu_a_out, data_alu_b_out);
    end
    rst_n = 1'b1; valid_in = 1'b0;
    wb(5'd5, 32'h0000AAAA);
    ins = r_type(5'd5, 5'd5, 5'd14);
    drive(ins, 20'h00001);
    push_exp(ins, 20'h00001, 8'h80, 5'd14, rf[5], rf[5]);
    tick();
    // Reset while another instruction is presented discards it and clears the bank.
    rst_n = 1'b0;
    drive(r_type(5'd5, 5'd5, 5'd15), 20'h00002);
    tick();
    checks++;
    if (valid_out !== 1'b0 || instruction_out !== 32'h0) begin
      failures++;
      $display("FAIL midop_reset: got valid=%b instr=%h, expected 0/00000000",
               valid_out, instruction_out);
    end
    rst_n = 1'b1; valid_in = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    ins = r_type(5'd5, 5'd0, 5'd1);
    drive(ins, 20'h00003);
    push_exp(ins, 20'h00003, 8'h80, 5'd1, 32'h0, 32'h0);
    tick();
    valid_in = 1'b0;
  endtask

  task automatic test_regread;
    logic [31:0] ins;
    wb(5'd3, 32'hDEADBEEF);
    ins = r_type(5'd3, 5'd3, 5'd4);
    drive(ins, 20'h00010);
    push_exp(ins, 20'h00010, 8'h80, 5'd4, 32'hDEADBEEF, 32'hDEADBEEF);
    tick();
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1 || reg_wr_addr_out !== 5'd4) begin
      failures++;
      $display("FAIL regread_dest: got valid=%b rd=%0d, expected 1/4", valid_out, reg_wr_addr_out);
    end
    tick();
  endtask

  task automatic test_load_use;
    logic [31:0] lw, add;
    wb(5'd1, 32'h00000011);
    wb(5'd2, 32'h00000022);
    lw = i_type(6'h23, 5'd1, 5'd2, 16'h0008);
    drive(lw, 20'h00020);
    push_exp(lw, 20'h00020, 8'hD0, 5'd2, rf[1], rf[2]);
    tick();
    add = r_type(5'd2, 5'd1, 5'd6);
    drive(add, 20'h00021);
    push_exp(add, 20'h00021, 8'h80, 5'd6, rf[2], rf[1]);
    #1;
    checks++;
    if (stall_out !== 1'b1) begin
      failures++;
      $display("FAIL load_use_stall: got stall=%b, expected 1", stall_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0 || stall_out !== 1'b0) begin
      failures++;
      $display("FAIL load_use_bubble: got valid=%b stall=%b, expected 0/0", valid_out, stall_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b1 || instruction_out !== add) begin
      failures++;
      $display("FAIL load_use_resume: got valid=%b instr=%h, expected 1/%h",
               valid_out, instruction_out, add);
    end
    valid_in = 1'b0;
    tick();
  endtask

  task automatic test_r0_and_jal;
    logic [31:0] lw0, add, jal;
    lw0 = i_type(6'h23, 5'd1, 5'd0, 16'h0004);
    drive(lw0, 20'h00030);
    push_exp(lw0, 20'h00030, 8'h50, 5'd0, rf[1], 32'h0);
    tick();
    add = r_type(5'd0, 5'd0, 5'd8);
    drive(add, 20'h00031);
    push_exp(add, 20'h00031, 8'h80, 5'd8, 32'h0, 32'h0);
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      failures++;
      $display("FAIL r0_no_stall: got stall=%b, expected 0", stall_out);
    end
    tick();
    jal = j_type(6'h03, 26'h0123456);
    drive(jal, 20'h00032);
    push_exp(jal, 20'h00032, 8'h82, 5'd31, rf[jal[25:21]], rf[jal[20:16]]);
    tick();
    valid_in = 1'b0;
    checks++;
    if (reg_wr_addr_out !== 5'd31 || ctrl_out[1] !== 1'b1 || pc_offset_out !== 26'h0123456) begin
      failures++;
      $display("FAIL jal_fields: got rd=%0d jump=%b off=%h, expected 31/1/0123456",
               reg_wr_addr_out, ctrl_out[1], pc_offset_out);
    end
    tick();
  endtask

  task automatic test_flush;
    logic [31:0] lw9;
    lw9 = i_type(6'h23, 5'd1, 5'd9, 16'h0000);
    drive(lw9, 20'h00040);
    push_exp(lw9, 20'h00040, 8'hD0, 5'd9, rf[1], rf[9]);
    tick();
    drive(r_type(5'd9, 5'd9, 5'd10), 20'h00041);
    #1;
    checks++;
    if (stall_out !== 1'b1) begin
      failures++;
      $display("FAIL flush_pre_hazard: got stall=%b, expected 1", stall_out);
    end
    flush_in = 1'b1;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      failures++;
      $display("FAIL flush_stall: got stall=%b, expected 0", stall_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      failures++;
      $display("FAIL flush_bubble: got valid=%b, expected 0", valid_out);
    end
    flush_in = 1'b0;
    valid_in = 1'b0;
    tick();
  endtask

  task automatic test_ex_stall;
    logic [31:0] add, sw;
    add = r_type(5'd3, 5'd1, 5'd11);
    drive(add, 20'h00050);
    push_exp(add, 20'h00050, 8'h80, 5'd11, rf[3], rf[1]);
    tick();
    sw = i_type(6'h2B, 5'd1, 5'd3, 16'hFFFC);
    drive(sw, 20'h00051);
    ex_stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (stall_out !== 1'b1) begin
        failures++;
        $display("FAIL ex_stall_out_%0d: got stall=%b, expected 1", i, stall_out);
      end
      tick();
      checks++;
      if (valid_out !== 1'b1 || instruction_out !== add || data_alu_a_out !== rf[3]) begin
        failures++;
        $display("FAIL ex_stall_hold_%0d: got valid=%b instr=%h a=%h, expected 1/%h/%h",
                 i, valid_out, instruction_out, data_alu_a_out, add, rf[3]);
      end
    end
    ex_stall_in = 1'b0;
    push_exp(sw, 20'h00051, 8'h20, 5'd0, rf[1], rf[3]);
    tick();
    valid_in = 1'b0;
    tick();
  endtask

  task automatic test_wb_same_cycle;
    logic [31:0] ins;
    wb(5'd7, 32'h00000077);
    ins = r_type(5'd7, 5'd0, 5'd12);
    wb_write_enable = 1'b1; wb_reg_wr_addr = 5'd7; wb_write_data = 32'h00000055;
    drive(ins, 20'h00060);
`ifdef DECODE_WB_BYPASS_EN
    push_exp(ins, 20'h00060, 8'h80, 5'd12, 32'h00000055, 32'h0);
`else
    push_exp(ins, 20'h00060, 8'h80, 5'd12, 32'h00000077, 32'h0);
`endif
    tick();
    wb_write_enable = 1'b0;
    rf[7] = 32'h00000055;
    ins = r_type(5'd7, 5'd7, 5'd13);
    drive(ins, 20'h00061);
    push_exp(ins, 20'h00061, 8'h80, 5'd13, rf[7], rf[7]);
    tick();
    valid_in = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [31:0] ins [7];
    logic [7:0]  ctl [7];
    logic [4:0]  rdx [7];
    ins[0] = i_type(6'h04, 5'd3, 5'd0, 16'h0010);  ctl[0] = 8'h04; rdx[0] = 5'd0;
    ins[1] = i_type(6'h05, 5'd1, 5'd0, 16'hFFF0);  ctl[1] = 8'h04; rdx[1] = 5'd0;
    ins[2] = i_type(6'h12, 5'd3, 5'd0, 16'h0000);  ctl[2] = 8'h03; rdx[2] = 5'd0;
    ins[3] = i_type(6'h13, 5'd3, 5'd0, 16'h0000);  ctl[3] = 8'h83; rdx[3] = 5'd31;
    ins[4] = i_type(6'h08, 5'd3, 5'd13, 16'h8000); ctl[4] = 8'h88; rdx[4] = 5'd13;
    ins[5] = r_type(5'd3, 5'd1, 5'd0);             ctl[5] = 8'h00; rdx[5] = 5'd0;
    ins[6] = j_type(6'h02, 26'h3FFFFFF);           ctl[6] = 8'h02; rdx[6] = 5'd0;
    for (int i = 0; i < 7; i++) begin
      drive(ins[i], 20'h00070 + 20'(i));
      push_exp(ins[i], 20'h00070 + 20'(i), ctl[i], rdx[i], rf[ins[i][25:21]], rf[ins[i][20:16]]);
      tick();
    end
    valid_in = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_regread();
    test_load_use();
    test_r0_and_jal();
    test_flush();
    test_ex_stall();
    test_wb_same_cycle();
    test_back_to_back();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
